// File: rtl/cpu_alu_sequencer.sv
// Execute-stage sequencer for a 6502-style core: drives the external ALU, owns the
// status register P and runs the read / dummy-write / write bus pattern for RMW shifts.
module cpu_alu_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  // Request handshake: a request is taken on a rising edge where req_valid && req_ready.
  // req_ready is high only in IDLE; rsp_valid is a single-cycle pulse with no backpressure.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_op,
  input  logic [7:0]        req_a,
  input  logic [7:0]        req_b,
  input  logic              req_rmw,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        alu_in1,
  output logic [7:0]        alu_in2,
  output logic [7:0]        alu_sel,
  output logic [7:0]        alu_status,
  input  logic [7:0]        alu_out,
  input  logic [7:0]        alu_next_status,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              p_load,
  input  logic [7:0]        p_wdata,
  output logic [7:0]        p,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {IDLE, EXEC, RD, DUMMY, WRITE, RESP} state_e;

  state_e              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [7:0]          a_q, a_d;
  logic [7:0]          b_q, b_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          result_q, result_d;
  logic [7:0]          opnd_q, opnd_d;
  logic [7:0]          p_q, p_d;

  logic op_legal;
  logic op_shift;

  assign op_legal = (req_op >= 8'h01) && (req_op <= 8'h18);
  assign op_shift = (req_op >= 8'h0B) && (req_op <= 8'h0E);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 8'h00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      addr_q   <= '0;
      result_q <= 8'h00;
      opnd_q   <= 8'h00;
      p_q      <= 8'h24;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      opnd_q   <= opnd_d;
      p_q      <= p_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    addr_d    = addr_q;
    result_d  = result_q;
    opnd_d    = opnd_q;
    p_d       = p_q;
    req_ready = 1'b0;
    alu_sel   = 8'h00;
    alu_in1   = 8'h00;
    alu_in2   = 8'h00;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    rsp_valid = 1'b0;

    // A direct load is overridden below by any ALU status update in the same cycle.
    if (p_load) p_d = p_wdata | 8'h20;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_legal ? req_op : 8'h00;
          a_d     = req_a;
          b_d     = req_b;
          addr_d  = req_addr;
          state_d = (req_rmw && op_shift) ? RD : EXEC;
        end
      end
      EXEC: begin
        // Illegal ops were latched as 8'h00: pass operand a through, leave P alone.
        if (op_q != 8'h00) begin
          alu_sel  = op_q;
          alu_in1  = a_q;
          alu_in2  = b_q;
          result_d = alu_out;
          p_d      = alu_next_status | 8'h20;
        end else begin
          result_d = a_q;
        end
        state_d = RESP;
      end
      RD: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        state_d  = DUMMY;
      end
      DUMMY: begin
        opnd_d    = mem_rdata;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = mem_rdata;
        state_d   = WRITE;
      end
      WRITE: begin
        alu_sel   = op_q;
        alu_in1   = opnd_q;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = alu_out;
        result_d  = alu_out;
        p_d       = alu_next_status | 8'h20;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_status = p_q;
  assign p          = p_q;
  assign rsp_data   = result_q;
  assign dbg_state  = state_q;

endmodule
